// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Compares ID source registers against the EX and MEM destinations and
// registers per-source forward selects at the ID/EX boundary, so they
// take effect in EX. A load-use hazard produces a STALL_CYCLES-long
// stall/bubble. A small FSM with a down-counter covers stall cycles
// beyond the first one.
module fwd_hazard_unit #(
  parameter int AW           = 5,
  parameter int NUM_SRC      = 2,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC*AW-1:0]  id_rs_addr,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic [AW-1:0]          ex_rd_addr,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic [AW-1:0]          mem_rd_addr,
  input  logic                   mem_reg_write,
  input  logic                   hold,
  input  logic                   flush,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // The first stall cycle is purely combinational. Only the remaining
  // STALL_CYCLES-1 cycles need the FSM, so the counter loads that value.
  localparam bit               MULTI_CYCLE = (STALL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*NUM_SRC-1:0]   fwd_sel_q, fwd_sel_d;
  logic [2*NUM_SRC-1:0]   next_sel;
  logic [NUM_SRC-1:0]     hit_e, hit_m;
  logic                   lu;
  logic                   stall_int;

  // Per-source match against the EX and MEM destinations. x0 never
  // matches, and the EX hit wins because it holds the younger value.
  always_comb begin
    hit_e    = '0;
    hit_m    = '0;
    next_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_e[i] = id_rs_used[i] & ex_reg_write &
                 (ex_rd_addr == id_rs_addr[i*AW +: AW]) &
                 (id_rs_addr[i*AW +: AW] != '0);
      hit_m[i] = id_rs_used[i] & mem_reg_write &
                 (mem_rd_addr == id_rs_addr[i*AW +: AW]) &
                 (id_rs_addr[i*AW +: AW] != '0);
      if (hit_e[i]) begin
        next_sel[2*i +: 2] = 2'b01;
      end else if (hit_m[i]) begin
        next_sel[2*i +: 2] = 2'b10;
      end else begin
        next_sel[2*i +: 2] = 2'b00;
      end
    end
  end

  // Load-use detection and the zero-latency stall. Flush and reset both
  // suppress the stall.
  always_comb begin
    lu        = ex_mem_read & (|hit_e);
    stall_int = reset & ~flush &
                (((state_q == IDLE) & lu) | (state_q == STALL));
  end

  // Next-state logic for the FSM, the counter and the registered selects.
  // Hold freezes everything. Flush aborts any stall. A stalled cycle
  // pushes a bubble into EX, so it has nothing to forward.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwd_sel_d = fwd_sel_q;
    if (!hold) begin
      if (flush) begin
        state_d   = IDLE;
        cnt_d     = '0;
        fwd_sel_d = '0;
      end else begin
        fwd_sel_d = stall_int ? '0 : next_sel;
        case (state_q)
          IDLE: begin
            if (MULTI_CYCLE && lu) begin
              state_d = STALL;
              cnt_d   = CNT_LOAD;
            end
          end
          STALL: begin
            if (cnt_q == CNT_ONE) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // State, counter and forward-select registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  // Output assignments. bubble is the same signal as stall.
  always_comb begin
    fwd_sel = fwd_sel_q;
    stall   = stall_int;
    bubble  = stall_int;
    busy    = (state_q == STALL);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard testbench for fwd_hazard_unit (STALL_CYCLES=3). The
// stimulus process drives one vector per cycle just after the rising
// edge and pushes the outputs expected at the following falling edge.
// The monitor pops and compares on every falling edge.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic        hold;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        bubble;
  logic        busy;

  typedef struct {
    string      name;
    logic [3:0] fwd;
    logic       stall;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  fwd_hazard_unit #(
    .AW(5), .NUM_SRC(2), .STALL_CYCLES(3), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used),
    .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write),
    .hold(hold),
    .flush(flush),
    .fwd_sel(fwd_sel),
    .stall(stall),
    .bubble(bubble),
    .busy(busy)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one field and record the outcome
  task automatic check_output(input string nm, input string field,
                              input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%b required=%b", nm, field, act, req);
    end
  endtask

  // Monitor: on every falling edge, pop the pending expectation and compare
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output(e.name, "fwd_sel", fwd_sel, e.fwd);
      check_output(e.name, "stall", {3'b0, stall}, {3'b0, e.stall});
      check_output(e.name, "bubble", {3'b0, bubble}, {3'b0, e.stall});
      check_output(e.name, "busy", {3'b0, busy}, {3'b0, e.busy});
    end
  end

  // Drive one cycle of inputs, queue the expected outputs, advance a cycle
  task automatic apply_stimulus(input string nm,
                                input logic [9:0] rs, input logic [1:0] used,
                                input logic [4:0] exrd, input logic exwr, input logic exmr,
                                input logic [4:0] memrd, input logic memwr,
                                input logic hld, input logic fls,
                                input logic [3:0] efwd, input logic estall, input logic ebusy);
    exp_t e;
    id_rs_addr    = rs;
    id_rs_used    = used;
    ex_rd_addr    = exrd;
    ex_reg_write  = exwr;
    ex_mem_read   = exmr;
    mem_rd_addr   = memrd;
    mem_reg_write = memwr;
    hold          = hld;
    flush         = fls;
    e.name  = nm;
    e.fwd   = efwd;
    e.stall = estall;
    e.busy  = ebusy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Cycle with no hazards anywhere
  task automatic idle(input string nm, input logic [3:0] efwd);
    apply_stimulus(nm, 10'h0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, efwd, 1'b0, 1'b0);
  endtask

  // Load-use vector: EX loads x4, ID reads x4 as rs2
  task automatic load_use(input string nm, input logic fls,
                          input logic [3:0] efwd, input logic estall, input logic ebusy);
    apply_stimulus(nm, {5'd4, 5'd0}, 2'b10, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, fls, efwd, estall, ebusy);
  endtask

  // Stall cycle with a bubble in EX; hold is selectable
  task automatic bubble_cycle(input string nm, input logic hld);
    apply_stimulus(nm, {5'd4, 5'd0}, 2'b10, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, hld, 1'b0, 4'b0000, 1'b1, 1'b1);
  endtask

  // Load result now in MEM: no stall, and forward from MEM/WB next cycle
  task automatic load_in_mem(input string nm);
    apply_stimulus(nm, {5'd4, 5'd0}, 2'b10, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  // ALU dependency: EX writes x5, ID reads x5 as rs1
  task automatic alu_dep(input string nm, input logic fls, input logic [3:0] efwd);
    apply_stimulus(nm, {5'd0, 5'd5}, 2'b01, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, fls, efwd, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    id_rs_addr = '0; id_rs_used = '0; ex_rd_addr = '0; ex_reg_write = 1'b0;
    ex_mem_read = 1'b0; mem_rd_addr = '0; mem_reg_write = 1'b0;
    hold = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state. A load-use pattern is present but must not stall.
    load_use("reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    idle("idle0", 4'b0000);

    // Test 1: back-to-back ALU dependency
    alu_dep("t1_alu", 1'b0, 4'b0000);
    idle("t1_fwd", 4'b0001);

    // Test 2: EX has priority over MEM, then MEM only
    apply_stimulus("t2_both", {5'd7, 5'd7}, 2'b11, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    apply_stimulus("t2_memonly", {5'd7, 5'd7}, 2'b11, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
    idle("t2_fwd", 4'b1010);

    // Test 3: x0 (even as a load) and an unused operand never match
    apply_stimulus("t3_x0", {5'd9, 5'd0}, 2'b01, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle("t3_fwd", 4'b0000);
    apply_stimulus("t3_unused_load", {5'd0, 5'd6}, 2'b10, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle("t3b_fwd", 4'b0000);

    // Test 4: three-cycle load-use stall
    load_use("t4_c0", 1'b0, 4'b0000, 1'b1, 1'b0);
    bubble_cycle("t4_c1", 1'b0);
    bubble_cycle("t4_c2", 1'b0);
    load_in_mem("t4_c3");
    idle("t4_fwd", 4'b1000);
    idle("t4_clr", 4'b0000);

    // Test 4b: two hold cycles mid-stall stretch it to five cycles
    load_use("t4h_c0", 1'b0, 4'b0000, 1'b1, 1'b0);
    bubble_cycle("t4h_c1", 1'b0);
    bubble_cycle("t4h_c2_hold", 1'b1);
    bubble_cycle("t4h_c3_hold", 1'b1);
    bubble_cycle("t4h_c4", 1'b0);
    load_in_mem("t4h_c5");
    idle("t4h_fwd", 4'b1000);
    idle("t4h_clr", 4'b0000);

    // Test 5: flush during a stall, flush with a load-use, flush clears fwd_sel
    load_use("t5_c0", 1'b0, 4'b0000, 1'b1, 1'b0);
    load_use("t5_flush", 1'b1, 4'b0000, 1'b0, 1'b1);
    idle("t5_after", 4'b0000);
    load_use("t5_flush_lu", 1'b1, 4'b0000, 1'b0, 1'b0);
    idle("t5_after_lu", 4'b0000);
    alu_dep("t5_dep", 1'b0, 4'b0000);
    alu_dep("t5_flush_fwd", 1'b1, 4'b0001);
    idle("t5_flushed", 4'b0000);

    // Test 6a: asynchronous reset while fwd_sel is nonzero
    alu_dep("t6_dep", 1'b0, 4'b0000);
    reset = 1'b0;
    alu_dep("t6_rst_fwd", 1'b0, 4'b0000);
    reset = 1'b1;
    alu_dep("t6_resume", 1'b0, 4'b0000);
    idle("t6_fwd", 4'b0001);

    // Test 6b: asynchronous reset in the middle of a stall
    load_use("t6s_c0", 1'b0, 4'b0000, 1'b1, 1'b0);
    bubble_cycle("t6s_c1", 1'b0);
    reset = 1'b0;
    load_use("t6s_rst", 1'b0, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    alu_dep("t6s_idle", 1'b0, 4'b0000);
    idle("t6s_fwd", 4'b0001);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
